// File: rtl/gcd_controller.sv
// gcd_controller: control FSM for a 16-bit subtractive GCD datapath
// Loads A and B over a valid/ready handshake, then steers A-B / B-A until equal.
module gcd_controller #(
  parameter int CNT_W    = 16,
  parameter int MAX_ITER = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic             gt,
  input  logic             lt,
  input  logic             eq,
  output logic             ldA,
  output logic             ldB,
  output logic             sel1,
  output logic             sel2,
  output logic             sel_in,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] iter_count
);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, CHECK, SUB_A, SUB_B, DONE, ERR} state_t;
  localparam logic [CNT_W-1:0] MAX = CNT_W'(MAX_ITER);
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_iter;
  assign iter_count = r_iter;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_iter  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) r_iter <= '0;
      else if (r_state == SUB_A || r_state == SUB_B) r_iter <= r_iter + CNT_W'(1);
    end
  end
  // eq wins over the iteration limit so a result reached on the last step still completes
  always_comb begin
    w_next     = r_state;
    data_ready = 1'b0;
    ldA        = 1'b0;
    ldB        = 1'b0;
    sel1       = 1'b0;
    sel2       = 1'b0;
    sel_in     = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    busy       = r_state != IDLE;
    case (r_state)
      IDLE:   w_next = start ? LOAD_A : IDLE;
      LOAD_A: begin
        data_ready = 1'b1;
        sel_in     = 1'b1;
        ldA        = data_valid;
        w_next     = data_valid ? LOAD_B : LOAD_A;
      end
      LOAD_B: begin
        data_ready = 1'b1;
        sel_in     = 1'b1;
        ldB        = data_valid;
        w_next     = data_valid ? CHECK : LOAD_B;
      end
      CHECK:  w_next = eq ? DONE : (r_iter == MAX) ? ERR : gt ? SUB_A : lt ? SUB_B : CHECK;
      SUB_A: begin
        sel2   = 1'b1;
        ldA    = 1'b1;
        w_next = CHECK;
      end
      SUB_B: begin
        sel1   = 1'b1;
        ldB    = 1'b1;
        w_next = CHECK;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      ERR: begin
        error  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_gcd_controller.sv
// tb_gcd_controller: drives gcd_controller against a behavioural datapath and GCD model
module tb_gcd_controller;
  localparam int MAXI = 10;
  logic clk = 0, rst_n = 0, start = 0, data_valid = 0;
  logic data_ready, ldA, ldB, sel1, sel2, sel_in, busy, done, error;
  logic [15:0] iter_count;
  logic [15:0] ra = 0, rb = 0, data_in = 0, bus;
  logic gt, lt, eq;
  int checks = 0, errors = 0;
  int r_cyc, r_viol, r_nsub, r_sig;
  bit r_done, r_err, r_post;
  logic [8:0] r_snap;
  logic [15:0] r_snap_iter, r_iter_before;

  gcd_controller #(.CNT_W(16), .MAX_ITER(MAXI)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_valid(data_valid), .data_ready(data_ready),
    .gt(gt), .lt(lt), .eq(eq), .ldA(ldA), .ldB(ldB), .sel1(sel1), .sel2(sel2), .sel_in(sel_in),
    .busy(busy), .done(done), .error(error), .iter_count(iter_count)
  );

  always #5 clk = ~clk;
  assign gt  = ra > rb;
  assign lt  = ra < rb;
  assign eq  = ra == rb;
  assign bus = sel_in ? data_in : (sel1 ? rb : ra) - (sel2 ? rb : ra);
  always @(posedge clk) begin
    if (ldA) ra <= bus;
    if (ldB) rb <= bus;
  end

  // Euclid by repeated subtraction, capped at the step limit; sig records A-subtractions as 1s
  task automatic model(input int a, input int b, output int res, output int n, output int sig, output bit ok);
    n = 0;
    sig = 0;
    while (a != b && n < MAXI) begin
      if (a > b) begin a -= b; sig = (sig << 1) | 1; end
      else begin b -= a; sig = sig << 1; end
      n++;
    end
    ok = (a == b);
    res = a;
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int sa, input int sb,
                        input bit noise, input int abort_at);
    int phase, wa, wb, limit;
    logic [15:0] it;
    r_cyc = 0; r_done = 0; r_err = 0; r_viol = 0; r_nsub = 0; r_sig = 0; r_post = 0;
    r_snap = '1; r_snap_iter = '1; r_iter_before = '1; it = '0;
    wa = sa; wb = sb; phase = 0; limit = 2 * MAXI + 12 + sa + sb;
    @(negedge clk);
    start = 1;
    data_valid = 0;
    @(posedge clk);
    while (r_cyc < limit) begin
      @(negedge clk);
      r_cyc++;
      start = noise;
      if (phase == 0) begin data_in = a; data_valid = (wa == 0); if (wa > 0) wa--; end
      else if (phase == 1) begin data_in = b; data_valid = (wb == 0); if (wb > 0) wb--; end
      else begin data_in = 16'($urandom); data_valid = 1'($urandom); end
      #1;
      if ((ldA && ldB) || !busy || (done && error)) r_viol++;
      if (phase < 2) begin
        if (!data_ready || !sel_in || ldA !== (phase == 0 && data_valid) || ldB !== (phase == 1 && data_valid)) r_viol++;
        if (data_valid) phase++;
      end else begin
        if (data_ready) r_viol++;
        if (ldA) begin if (sel_in || sel1 || !sel2) r_viol++; r_sig = (r_sig << 1) | 1; r_nsub++; end
        if (ldB) begin if (sel_in || !sel1 || sel2) r_viol++; r_sig = r_sig << 1; r_nsub++; end
        if (abort_at > 0 && ldA && r_nsub == abort_at) begin
          r_iter_before = iter_count;
          rst_n = 0;
          #1;
          r_snap = {ldA, ldB, sel1, sel2, sel_in, data_ready, busy, done, error};
          r_snap_iter = iter_count;
          start = 0;
          data_valid = 0;
          return;
        end
      end
      if (done || error) begin r_done = done; r_err = error; it = iter_count; break; end
    end
    start = 0;
    if (!(r_done || r_err)) return;
    @(negedge clk);
    data_valid = 0;
    #1;
    r_post = !busy && !done && !error && iter_count == it;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({ldA, ldB, sel1, sel2, sel_in, data_ready, busy, done, error} !== 9'b0 || iter_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_init: outputs=%b iter=%0d want 0", {ldA, ldB, sel1, sel2, sel_in, data_ready, busy, done, error}, iter_count);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    run_op(16'd48, 16'd18, 0, 0, 0, 2);
    checks++;
    if (r_iter_before !== 16'd1) begin errors++; $display("FAIL reset_pre_iter: got %0d want 1", r_iter_before); end
    checks++;
    if (r_snap !== 9'b0) begin errors++; $display("FAIL reset_async_outputs: got %b want 0", r_snap); end
    checks++;
    if (r_snap_iter !== 16'd0) begin errors++; $display("FAIL reset_async_iter: got %0d want 0", r_snap_iter); end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_basic;
    int ta[3] = '{12, 7, 48};
    int tb[3] = '{8, 7, 18};
    int tr[3] = '{4, 7, 6};
    int tn[3] = '{2, 0, 4};
    int ts[3] = '{2, 0, 13};
    for (int i = 0; i < 3; i++) begin
      run_op(16'(ta[i]), 16'(tb[i]), 0, 0, 0, 0);
      checks++;
      if (!r_done || r_err || r_cyc != 2 * tn[i] + 4) begin
        errors++;
        $display("FAIL basic_%0d_%0d latency: done=%0b err=%0b cycle=%0d want done at %0d", ta[i], tb[i], r_done, r_err, r_cyc, 2 * tn[i] + 4);
      end
      checks++;
      if (ra !== 16'(tr[i]) || rb !== 16'(tr[i])) begin
        errors++;
        $display("FAIL basic_%0d_%0d result: A=%0d B=%0d want %0d", ta[i], tb[i], ra, rb, tr[i]);
      end
      checks++;
      if (iter_count !== 16'(tn[i]) || r_nsub != tn[i] || r_sig != ts[i]) begin
        errors++;
        $display("FAIL basic_%0d_%0d steps: iter=%0d subs=%0d seq=%0h want %0d/%0d/%0h", ta[i], tb[i], iter_count, r_nsub, r_sig, tn[i], tn[i], ts[i]);
      end
      checks++;
      if (r_viol != 0 || !r_post) begin
        errors++;
        $display("FAIL basic_%0d_%0d protocol: violations=%0d post_idle=%0b want 0/1", ta[i], tb[i], r_viol, r_post);
      end
    end
  endtask

  task automatic test_stall;
    run_op(16'd12, 16'd8, 3, 2, 0, 0);
    checks++;
    if (!r_done || r_cyc != 13) begin errors++; $display("FAIL stall_latency: done=%0b cycle=%0d want done at 13", r_done, r_cyc); end
    checks++;
    if (ra !== 16'd4 || rb !== 16'd4) begin errors++; $display("FAIL stall_result: A=%0d B=%0d want 4", ra, rb); end
    checks++;
    if (r_viol != 0) begin errors++; $display("FAIL stall_handshake: violations=%0d want 0", r_viol); end
  endtask

  task automatic test_error;
    int ea[4] = '{0, 5, 12, 1};
    int eb[4] = '{5, 0, 1, 12};
    for (int i = 0; i < 4; i++) begin
      run_op(16'(ea[i]), 16'(eb[i]), 0, 0, 0, 0);
      checks++;
      if (!r_err || r_done || r_cyc != 2 * MAXI + 4) begin
        errors++;
        $display("FAIL error_%0d_%0d: err=%0b done=%0b cycle=%0d want err at %0d", ea[i], eb[i], r_err, r_done, r_cyc, 2 * MAXI + 4);
      end
      checks++;
      if (iter_count !== 16'(MAXI) || r_nsub != MAXI || r_viol != 0 || !r_post) begin
        errors++;
        $display("FAIL error_%0d_%0d steps: iter=%0d subs=%0d viol=%0d post=%0b want %0d", ea[i], eb[i], iter_count, r_nsub, r_viol, r_post, MAXI);
      end
    end
    run_op(16'd0, 16'd0, 0, 0, 0, 0);
    checks++;
    if (!r_done || r_cyc != 4 || ra !== 16'd0 || iter_count !== 16'd0) begin
      errors++;
      $display("FAIL zero_zero: done=%0b cycle=%0d A=%0d iter=%0d want done at 4, 0, 0", r_done, r_cyc, ra, iter_count);
    end
    run_op(16'd11, 16'd1, 0, 0, 0, 0);
    checks++;
    if (!r_done || r_err || r_cyc != 2 * MAXI + 4 || iter_count !== 16'(MAXI) || ra !== 16'd1) begin
      errors++;
      $display("FAIL limit_exact: done=%0b err=%0b cycle=%0d iter=%0d A=%0d want done at %0d iter %0d A 1", r_done, r_err, r_cyc, iter_count, ra, 2 * MAXI + 4, MAXI);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 2; i++) begin
      run_op(16'd21, 16'd6, 0, 0, i == 0, 0);
      checks++;
      if (!r_done || r_cyc != 12 || ra !== 16'd3 || rb !== 16'd3 || iter_count !== 16'd4) begin
        errors++;
        $display("FAIL b2b_%0d: done=%0b cycle=%0d A=%0d B=%0d iter=%0d want 12/3/3/4", i, r_done, r_cyc, ra, rb, iter_count);
      end
      checks++;
      if (!r_post || r_viol != 0) begin
        errors++;
        $display("FAIL b2b_%0d_idle: post_idle=%0b violations=%0d want 1/0", i, r_post, r_viol);
      end
    end
  endtask

  task automatic test_random;
    int a, b, sa, sb, res, n, sig, exp_cyc;
    bit ok;
    for (int i = 0; i < 24; i++) begin
      a = $urandom_range(0, 30);
      b = $urandom_range(0, 30);
      sa = $urandom_range(0, 2);
      sb = $urandom_range(0, 2);
      model(a, b, res, n, sig, ok);
      exp_cyc = 2 * n + 4 + sa + sb;
      run_op(16'(a), 16'(b), sa, sb, 1'($urandom), 0);
      checks++;
      if (r_done != ok || r_err != !ok || r_cyc != exp_cyc) begin
        errors++;
        $display("FAIL rand_%0d_%0d outcome: done=%0b err=%0b cycle=%0d want done=%0b at %0d", a, b, r_done, r_err, r_cyc, ok, exp_cyc);
      end
      checks++;
      if (iter_count !== 16'(n) || r_sig != sig || (ok && (ra !== 16'(res) || rb !== 16'(res)))) begin
        errors++;
        $display("FAIL rand_%0d_%0d value: iter=%0d seq=%0h A=%0d B=%0d want %0d/%0h/%0d", a, b, iter_count, r_sig, ra, rb, n, sig, res);
      end
      checks++;
      if (r_viol != 0 || !r_post) begin
        errors++;
        $display("FAIL rand_%0d_%0d protocol: violations=%0d post_idle=%0b want 0/1", a, b, r_viol, r_post);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_error();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
